// File: rtl/gamma_seq.sv
// Gamma-correction sequencer: time-shares one registered 8-bit LUT across the R, G and B channels
// of a valid/ready pixel stream, with a latched per-pixel bypass mode.
module gamma_seq #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sof,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  output logic [7:0]       lut_addr,
  input  logic [7:0]       lut_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b,
  output logic             busy,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LK_R  = 3'd1;
  localparam logic [2:0] LK_G  = 3'd2;
  localparam logic [2:0] LK_B  = 3'd3;
  localparam logic [2:0] CAP_B = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [7:0]       r_q, g_q, b_q;
  logic [7:0]       res_r_q, res_g_q;
  logic             bypass_q;
  logic [7:0]       out_r_q, out_g_q, out_b_q;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic             accept, out_hs;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_r     = out_r_q;
  assign out_g     = out_g_q;
  assign out_b     = out_b_q;
  assign pix_count = pix_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = enable ? LK_R : OUT;
      LK_R:    state_d = LK_G;
      LK_G:    state_d = LK_B;
      LK_B:    state_d = CAP_B;
      CAP_B:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LUT is only addressed during the three lookup states of a corrected pixel.
  always_comb begin
    lut_addr = 8'h00;
    if (!bypass_q) begin
      case (state_q)
        LK_R:    lut_addr = r_q;
        LK_G:    lut_addr = g_q;
        LK_B:    lut_addr = b_q;
        default: lut_addr = 8'h00;
      endcase
    end
  end

  always_comb begin
    pix_count_d = pix_count_q;
    if (sof) begin
      pix_count_d = out_hs ? CNT_W'(1) : '0;
    end else if (out_hs) begin
      pix_count_d = pix_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= 8'h00;
      g_q         <= 8'h00;
      b_q         <= 8'h00;
      res_r_q     <= 8'h00;
      res_g_q     <= 8'h00;
      bypass_q    <= 1'b0;
      out_r_q     <= 8'h00;
      out_g_q     <= 8'h00;
      out_b_q     <= 8'h00;
      pix_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_count_q <= pix_count_d;
      if (accept) begin
        r_q      <= in_r;
        g_q      <= in_g;
        b_q      <= in_b;
        bypass_q <= ~enable;
        if (!enable) begin
          out_r_q <= in_r;
          out_g_q <= in_g;
          out_b_q <= in_b;
        end
      end
      // LUT data trails its address by one clock, so each capture lands one state later.
      case (state_q)
        LK_G:  res_r_q <= lut_data;
        LK_B:  res_g_q <= lut_data;
        CAP_B: begin
          out_r_q <= res_r_q;
          out_g_q <= res_g_q;
          out_b_q <= lut_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_seq.sv
// Directed bench for gamma_seq: vector table for the main paths plus hand-written sequences
// for backpressure, pixel counter/sof, counter wrap and mid-lookup reset.
module tb_gamma_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, sof = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_r = 8'h00, in_g = 8'h00, in_b = 8'h00;
  logic        in_ready, out_valid, busy;
  logic [7:0]  lut_addr, lut_data = 8'h00;
  logic [7:0]  out_r, out_g, out_b;
  logic [16:0] pix_count;
  logic        in_ready2, out_valid2, busy2;
  logic [7:0]  lut_addr2, out_r2, out_g2, out_b2;
  logic [1:0]  pix_count2;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  addr_seq [3];

  always #5 clk = ~clk;

  gamma_seq u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof), .in_valid(in_valid),
    .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b), .lut_addr(lut_addr),
    .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_g(out_g), .out_b(out_b), .busy(busy), .pix_count(pix_count)
  );

  // Narrow-counter copy runs in lockstep with the main instance to exercise wrap-around.
  gamma_seq #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof(sof), .in_valid(in_valid),
    .in_ready(in_ready2), .in_r(in_r), .in_g(in_g), .in_b(in_b), .lut_addr(lut_addr2),
    .lut_data(lut_data), .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2),
    .out_g(out_g2), .out_b(out_b2), .busy(busy2), .pix_count(pix_count2)
  );

  // Gamma 1/1.8 entries for the addresses the directed vectors use; others get a marker pattern.
  function automatic logic [7:0] gamma(input logic [7:0] x);
    case (x)
      8'h01:   gamma = 8'h0C;
      8'h02:   gamma = 8'h11;
      8'h03:   gamma = 8'h16;
      8'h04:   gamma = 8'h19;
      8'h10:   gamma = 8'h37;
      8'h40:   gamma = 8'h76;
      8'h80:   gamma = 8'hAE;
      8'hFF:   gamma = 8'hFF;
      default: gamma = x ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) lut_data <= gamma(lut_addr);

  typedef struct {
    logic       en;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
    int         lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents one pixel, waits for accept, then waits for out_valid. Leaves the output unconsumed.
  task automatic push(input logic en, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, output logic [7:0] orr, output logic [7:0] og,
                      output logic [7:0] ob, output int lat);
    int w;
    w = 0;
    enable = en; in_r = r; in_g = g; in_b = b; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (lat <= 3) addr_seq[lat-1] = lut_addr;
      tick();
      lat++;
    end
    orr = out_r; og = out_g; ob = out_b;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [7:0] xr, xg, xb;
    int l;
    push(1'b1, r, g, b, xr, xg, xb, l);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [5];
    logic [7:0] gr, gg, gb, sr, sg, sb;
    int         lat;

    vecs[0] = '{1'b1, 8'h01, 8'h80, 8'hFF, 8'h0C, 8'hAE, 8'hFF, 5};
    vecs[1] = '{1'b0, 8'h10, 8'h40, 8'h80, 8'h10, 8'h40, 8'h80, 1};
    vecs[2] = '{1'b1, 8'h10, 8'h40, 8'h80, 8'h37, 8'h76, 8'hAE, 5};
    vecs[3] = '{1'b1, 8'h02, 8'h03, 8'h04, 8'h11, 8'h16, 8'h19, 5};
    vecs[4] = '{1'b0, 8'hAB, 8'hCD, 8'hEF, 8'hAB, 8'hCD, 8'hEF, 1};

    // Reset and idle
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_pix_count", 32'(pix_count), 32'd0);
      check("idle_lut_addr", 32'(lut_addr), 32'd0);
      tick();
    end

    // Vector table, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].en, vecs[i].r, vecs[i].g, vecs[i].b, gr, gg, gb, lat);
      check($sformatf("vec%0d_r", i), 32'(gr), 32'(vecs[i].er));
      check($sformatf("vec%0d_g", i), 32'(gg), 32'(vecs[i].eg));
      check($sformatf("vec%0d_b", i), 32'(gb), 32'(vecs[i].eb));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      if (i == 0) begin
        check("lut_addr_r", 32'(addr_seq[0]), 32'h01);
        check("lut_addr_g", 32'(addr_seq[1]), 32'h80);
        check("lut_addr_b", 32'(addr_seq[2]), 32'hFF);
      end
      tick();
      check($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
    end
    check("count_after_table", 32'(pix_count), 32'd5);

    // Backpressure: hold the output for 10 clocks with a second pixel waiting
    out_ready = 1'b0;
    push(1'b1, 8'h20, 8'h21, 8'h22, sr, sg, sb, lat);
    check("bp_a_r", 32'(sr), 32'h85);
    check("bp_a_g", 32'(sg), 32'h84);
    check("bp_a_b", 32'(sb), 32'h87);
    enable = 1'b1; in_r = 8'h01; in_g = 8'h80; in_b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", {8'h00, out_r, out_g, out_b}, {8'h00, sr, sg, sb});
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_b_accepted", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_b_data", {8'h00, out_r, out_g, out_b}, 32'h000CAEFF);
    tick();

    // Counter and sof
    sof = 1'b1;
    tick();
    sof = 1'b0;
    check("sof_clear", 32'(pix_count), 32'd0);
    for (int i = 0; i < 4; i++) send(8'(i), 8'(i + 1), 8'(i + 2));
    check("count_4", 32'(pix_count), 32'd4);
    check("count2_4", 32'(pix_count2), 32'd0);
    push(1'b1, 8'h33, 8'h44, 8'h55, gr, gg, gb, lat);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    check("sof_with_hs", 32'(pix_count), 32'd1);

    // Wrap on the 2-bit counter
    sof = 1'b1;
    tick();
    sof = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h60, 8'h61, 8'h62);
    check("count_5", 32'(pix_count), 32'd5);
    check("count2_wrap", 32'(pix_count2), 32'd1);

    // Reset mid-lookup (during LK_G)
    enable = 1'b1; in_r = 8'h55; in_g = 8'h66; in_b = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset_lut_addr", 32'(lut_addr), 32'h66);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", {8'h00, out_r, out_g, out_b}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_lut_addr", 32'(lut_addr), 32'd0);
      check("rst_pix_count", 32'(pix_count), 32'd0);
      tick();
    end
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    push(1'b1, 8'h02, 8'h03, 8'h04, gr, gg, gb, lat);
    check("post_rst_pixel", {8'h00, gr, gg, gb}, 32'h00111619);
    check("post_rst_latency", 32'(lat), 32'd5);
    tick();
    check("post_rst_count", 32'(pix_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gamma_seq.md
Name: gamma_seq

Overview:
- Sequencer that time-shares one registered 8-bit gamma LUT across the R, G and B channels of a 24-bit pixel stream.
- Accepts one pixel on a valid/ready input, issues three LUT lookups, reassembles the corrected pixel and presents it on a valid/ready output.
- Sits between the camera pixel capture and the frame buffer writer. The gamma LUT instance is external and is driven through lut_addr and lut_data.

Parameters:
- CNT_W, 17, width of the output pixel counter (320x240 = 76800 fits).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = gamma correct; 0 = bypass (raw pixel passed through).
- sof  in  1  start of frame; clears pix_count.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_r, in_g, in_b  in  8 each  input channels.
- lut_addr  out  8  address to the gamma LUT.
- lut_data  in  8  LUT data, valid one clk after the matching lut_addr.
- out_valid  out  1  corrected pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_r, out_g, out_b  out  8 each  corrected channels.
- busy  out  1  high in any state other than IDLE.
- pix_count  out  CNT_W  pixels delivered since the last sof.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid, out_r/g/b, pix_count and captured registers = 0.
  - The bypass flag is cleared.
  - in_ready = 1 (it follows state IDLE), busy = 0, lut_addr = 0.
- States: IDLE, LK_R, LK_G, LK_B, CAP_B, OUT.
- IDLE: in_ready = 1. When in_valid & in_ready:
  - Capture in_r/g/b and latch bypass = ~enable.
  - Go to OUT if bypass, else LK_R.
- LK_R: lut_addr = r_q. Go to LK_G.
- LK_G: lut_addr = g_q; capture lut_data into res_r. Go to LK_B.
- LK_B: lut_addr = b_q; capture lut_data into res_g. Go to CAP_B.
- CAP_B: lut_addr = 0; capture lut_data into res_b. Load out_r/g/b from res_*. Go to OUT.
- Bypass path: the IDLE -> OUT transition loads out_r/g/b directly from the captured raw values.
- lut_addr is combinational from state and captured registers. It is 0 in IDLE, CAP_B and OUT.
- OUT: out_valid = 1; out_r/g/b are held stable until out_valid & out_ready, then go to IDLE. out_valid deasserts the cycle after the handshake.
- Latency, counted from the accept edge to the first cycle out_valid is high:
  - 5 clk in correct mode.
  - 1 clk in bypass mode.
- Throughput is 1 pixel per 6 clk (correct mode) or 2 clk (bypass) with out_ready held high.
- in_ready = 0 in every state except IDLE. No input pixel is accepted while the output is stalled.
- A change of enable mid-pixel has no effect; the mode is latched at accept only.
- pix_count:
  - Increments by 1 on each output handshake, wrapping from 2^CNT_W-1 to 0.
  - sof alone sets it to 0.
  - sof in the same cycle as an output handshake sets it to 1.
- out_ready held low in OUT: stay in OUT indefinitely with data stable.
- Reset asserted mid-lookup: the pixel is discarded and no partial output appears. After release, in_ready = 1 on the first clk.

Test Plan:
- Reset and idle: after rst_n release, check in_ready = 1, out_valid = 0, busy = 0, pix_count = 0, lut_addr = 0 for 3 clk.
- Correct path (real gamma LUT attached, enable = 1, out_ready = 1): push {0x01,0x80,0xFF} -> out = {0x0C,0xAE,0xFF}; out_valid exactly 5 clk after accept; lut_addr sequence 0x01,0x80,0xFF.
- Bypass (enable = 0): push {0x10,0x40,0x80} -> out = {0x10,0x40,0x80} one clk after accept. Re-run with enable = 1 -> {0x37,0x76,0xAE}.
- Backpressure: out_ready = 0 for 10 clk while in OUT -> out_valid stays 1, data stable, in_ready = 0, second pixel held off. Release -> second pixel accepted on the clk after the handshake.
- Counter and sof:
  - Stream 4 pixels -> pix_count = 4.
  - sof coincident with the 5th output handshake -> pix_count = 1.
  - With CNT_W = 2, 5 pixels -> pix_count wraps to 1.
- Reset mid-operation: assert rst_n low during LK_G -> out_valid never asserts for that pixel, all outputs 0. After release, a new pixel {0x02,0x03,0x04} -> {0x11,0x16,0x19}.
